// File: rtl/cc_encoder_pkg.sv
// Shared types and constants for the register-select encoder.
`default_nettype none

package cc_encoder_pkg;

  localparam int DATAWIDTH_ENCODER_SELECTION = 4;
  localparam int DATAWIDTH_ENCODER_IN        = 16;
  localparam int REGISTER_COUNT              = 14;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] REG_G0    = 4'd0;
  localparam logic [3:0] REG_G1    = 4'd1;
  localparam logic [3:0] REG_G2    = 4'd2;
  localparam logic [3:0] REG_G3    = 4'd3;
  localparam logic [3:0] REG_G4    = 4'd4;
  localparam logic [3:0] REG_G5    = 4'd5;
  localparam logic [3:0] REG_G6    = 4'd6;
  localparam logic [3:0] REG_G7    = 4'd7;
  localparam logic [3:0] REG_PC    = 4'd8;
  localparam logic [3:0] REG_TEMP0 = 4'd9;
  localparam logic [3:0] REG_TEMP1 = 4'd10;
  localparam logic [3:0] REG_TEMP2 = 4'd11;
  localparam logic [3:0] REG_TEMP3 = 4'd12;
  localparam logic [3:0] REG_IR    = 4'd13;

  localparam logic [15:0] MAPPED_MASK = 16'h3FFF;

endpackage

`default_nettype wire

// File: rtl/cc_priority_encoder.sv
// Combinational lowest-set-bit finder; any is high when at least one bit is set.
`default_nettype none

module cc_priority_encoder #(
  parameter int WIDTH = 14,
  parameter int IDX_W = 4
) (
  input  logic [WIDTH-1:0] req,
  output logic [IDX_W-1:0] index,
  output logic             any
);

  // Scan downwards so the lowest set bit is the last one written.
  always_comb begin
    index = '0;
    any   = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[i]) begin
        index = IDX_W'(i);
        any   = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/cc_select_encoder.sv
// Serialises an active-low multi-register select vector into a stream of
// register indices, lowest first, one per valid/ready handshake.
`default_nettype none

module cc_select_encoder
  import cc_encoder_pkg::*;
#(
  parameter int DATAWIDTH_ENCODER_SELECTION = cc_encoder_pkg::DATAWIDTH_ENCODER_SELECTION,
  parameter int DATAWIDTH_ENCODER_IN        = cc_encoder_pkg::DATAWIDTH_ENCODER_IN,
  parameter int REGISTER_COUNT              = cc_encoder_pkg::REGISTER_COUNT
) (
  input  logic                                   CLOCK_50,
  input  logic                                   RESET_InLow,
  input  logic [DATAWIDTH_ENCODER_IN-1:0]        CC_ENCODER_Select_InBUS,
  input  logic                                   CC_ENCODER_Load_In,
  input  logic                                   CC_ENCODER_Ready_In,
  output logic [DATAWIDTH_ENCODER_SELECTION-1:0] CC_ENCODER_Index_OutBUS,
  output logic                                   CC_ENCODER_Valid_Out,
  output logic                                   CC_ENCODER_Busy_Out,
  output logic                                   CC_ENCODER_Done_Out,
  output logic                                   CC_ENCODER_Error_Out,
  output logic [4:0]                             CC_ENCODER_Count_OutBUS
);

  localparam int RC = REGISTER_COUNT;
  localparam int IW = DATAWIDTH_ENCODER_SELECTION;

  state_t        state_q, state_d;
  logic [RC-1:0] pending_q, pending_d;
  logic [IW-1:0] index_q, index_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic [4:0]    count_q, count_d;

  logic [RC-1:0] captured;
  logic [RC-1:0] next_pending;
  logic [4:0]    captured_count;
  logic [IW-1:0] enc_index;
  logic          enc_any;
  logic          capture;
  logic          handshake;

  assign captured  = ~CC_ENCODER_Select_InBUS[RC-1:0];
  assign capture   = (state_q == IDLE) && CC_ENCODER_Load_In;
  assign handshake = (state_q == ISSUE) && valid_q && CC_ENCODER_Ready_In;

  always_comb begin
    captured_count = '0;
    for (int i = 0; i < RC; i++) begin
      captured_count = captured_count + 5'(captured[i]);
    end
  end

  // The single encoder looks at whatever the pending vector becomes this edge.
  always_comb begin
    next_pending = pending_q;
    if (capture) begin
      next_pending = captured;
    end else if (handshake) begin
      next_pending = pending_q & ~(RC'(1) << index_q);
    end
  end

  cc_priority_encoder #(
    .WIDTH (RC),
    .IDX_W (IW)
  ) u_prio (
    .req   (next_pending),
    .index (enc_index),
    .any   (enc_any)
  );

  always_comb begin
    state_d   = state_q;
    pending_d = next_pending;
    index_d   = index_q;
    valid_d   = valid_q;
    done_d    = 1'b0;
    error_d   = error_q;
    count_d   = count_q;
    case (state_q)
      IDLE: begin
        if (capture) begin
          error_d = |(~CC_ENCODER_Select_InBUS[DATAWIDTH_ENCODER_IN-1:RC]);
          count_d = captured_count;
          if (enc_any) begin
            state_d = ISSUE;
            valid_d = 1'b1;
            index_d = enc_index;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (handshake) begin
          count_d = count_q - 5'd1;
          if (enc_any) begin
            index_d = enc_index;
          end else begin
            valid_d = 1'b0;
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_InLow) begin
    if (!RESET_InLow) begin
      state_q   <= IDLE;
      pending_q <= '0;
      index_q   <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      index_q   <= index_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      count_q   <= count_d;
    end
  end

  assign CC_ENCODER_Index_OutBUS = index_q;
  assign CC_ENCODER_Valid_Out    = valid_q;
  assign CC_ENCODER_Busy_Out     = busy_q;
  assign CC_ENCODER_Done_Out     = done_q;
  assign CC_ENCODER_Error_Out    = error_q;
  assign CC_ENCODER_Count_OutBUS = count_q;

endmodule

`default_nettype wire
